jh_nonce_scheduler: RTL and testbench
=====================================

// Module: jh_nonce_scheduler
// PURPOSE
//  Sequences one jh_top core through a nonce sweep over an 80-byte block header.
//  Host loads 20x32b header words, target, nonce start and count, then writes start.
//  Per nonce the block streams a length header plus 10 message words, collects the 256b digest and compares it to target.
//  Stops on first hit or when count is exhausted.
// PARAMETERS
//  MSG_WORDS     10    64b message words per nonce; address map is fixed for 10
//  DIG_WORDS     4     64b digest words returned per nonce
//  MSG_LEN_BITS  640   message length carried in the header word
// PORTS
//  clk             in   1    clock
//  reset           in   1    reset, synchronous, active-high
//  cfg_we          in   1    config write strobe
//  cfg_addr        in   5    0-19 header words (even=low half, odd=high half of msg[i/2]); 20/21 target lo/hi; 22 nonce_start; 23 nonce_count; 24 ctrl (b0 start, b1 abort)
//  cfg_wdata       in   32   config write data
//  jh_rst          out  1    core reset: reset OR one-cycle abort pulse
//  jh_src_ready_n  out  1    low = jh_din valid
//  jh_src_read     in   1    core consumes jh_din this cycle
//  jh_din          out  64   word to core
//  jh_dst_ready_n  out  1    low = scheduler accepts digest words
//  jh_dst_write    in   1    jh_dout valid this cycle
//  jh_dout         in   64   digest word from core
//  busy            out  1    sweep in progress
//  done            out  1    sticky; sweep finished; cleared by start
//  found           out  1    valid with done; a hit occurred
//  found_nonce     out  32   nonce of the hit
//  digest          out  256  last collected digest; first word lands in [63:0]
//  nonces_done     out  32   nonces fully checked in this sweep
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except jh_rst=1 and jh_src_ready_n=jh_dst_ready_n=1; config registers cleared.
//  FSM: IDLE -> (start, count!=0) SEND_HDR -> SEND_MSG -> WAIT_DIG -> CHECK -> SEND_HDR | DONE.
//  - start with count==0 -> DONE next cycle; found=0, nonces_done=0.
//  Start, taken in IDLE or DONE, latches:
//  - nonce=nonce_start, remaining=count, nonces_done=0.
//  - Clears done, found, found_nonce.
//  Start while busy is ignored.
//  SEND_HDR presents {(64-$bits(MSG_LEN_BITS))'0, MSG_LEN_BITS} with jh_src_ready_n=0; it advances on jh_src_read.
//  SEND_MSG presents msg[0..9] in order, one word per jh_src_read.
//  - msg[9][63:32] is replaced by the current nonce.
//  - jh_din is held stable while jh_src_ready_n=0 and no read occurs.
//  - jh_src_ready_n=1 in the cycle after the last read.
//  WAIT_DIG holds jh_dst_ready_n=0.
//  - Each jh_dst_write shifts digest <= {word, digest[255:64]}.
//  - After DIG_WORDS writes -> CHECK; jh_dst_ready_n=1 outside WAIT_DIG.
//  - jh_dst_write outside WAIT_DIG is ignored.
//  CHECK (1 cycle):
//  - nonces_done++; hit = digest[255:192] <= target (unsigned).
//  - On hit: found=1, found_nonce=nonce -> DONE.
//  - Else if remaining==1 -> DONE.
//  - Else nonce++ (wraps FFFFFFFF->0), remaining-- -> SEND_HDR.
//  DONE: done=1, busy=0; digest holds the last value.
//  Cost per nonce: 11 reads + 4 writes + 1 CHECK cycle, plus core latency.
//  Abort (any state): -> IDLE next cycle, jh_rst=1 for exactly one cycle; busy=0, done=0, found=0; config registers kept.
//  Start and abort in the same write: abort wins.
//  Config writes to addr 0-23 while busy are ignored; addr 25-31 are ignored.
// CONFIGURATION
//  JH_SCHED_BYTESWAP_EN defined:
//  - Each jh_dout word is byte-reversed (byte0<->byte7, ...) before shift/compare.
//  Undefined:
//  - Raw jh_dout is used.
// STRUCTURE
//  Package jh_sched_pkg:
//  - state enum (IDLE, SEND_HDR, SEND_MSG, WAIT_DIG, CHECK, DONE)
//  - cfg address constants (ADDR_TGT_LO=20 ... ADDR_CTRL=24)
//  - MSG_LEN_BITS
//  Sub-module jh_digest_collector (shift register, optional byteswap, word counter, compare):
//  - Outputs: digest, dig_full, hit.
// TESTING
//  1. Load header, start=5, count=1, target=FFFF..F, model core -> one SEND of 11 words, msg[9][63:32]=5, found=1, found_nonce=5, nonces_done=1.
//  2. target=0, model digests nonzero, start=FFFFFFFE, count=3 -> nonces FFFFFFFE, FFFFFFFF, 0 sent; done=1, found=0, nonces_done=3.
//  3. count=0 then start -> done=1 within 2 cycles, no jh_src_ready_n low, nonces_done=0.
//  4. Model stalls jh_src_read 7 cycles on word 4 -> jh_din stable, no word skipped or repeated.
//  5. Abort during WAIT_DIG after 2 digest words -> jh_rst high exactly 1 cycle, busy=0; restart completes normally.
//  6. With JH_SCHED_BYTESWAP_EN, jh_dout=0102030405060708 as last word -> digest[255:192]=0807060504030201.

Source files
------------

// File: rtl/jh_sched_pkg.sv
// Shared types and constants for the JH nonce scheduler: FSM states, config address map, message geometry.
package jh_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_MSG,
    WAIT_DIG,
    CHECK,
    DONE
  } state_t;

  localparam int MSG_WORDS    = 10;
  localparam int DIG_WORDS    = 4;
  localparam int MSG_LEN_BITS = 640;

  localparam logic [4:0] ADDR_TGT_LO      = 5'd20;
  localparam logic [4:0] ADDR_TGT_HI      = 5'd21;
  localparam logic [4:0] ADDR_NONCE_START = 5'd22;
  localparam logic [4:0] ADDR_NONCE_COUNT = 5'd23;
  localparam logic [4:0] ADDR_CTRL        = 5'd24;

  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[(7-i)*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/jh_digest_collector.sv
// Shifts DIG_WORDS core output words into a 256b digest and compares its top word against target.
// JH_SCHED_BYTESWAP_EN byte-reverses each incoming word before it is shifted in.
module jh_digest_collector
  import jh_sched_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         shift,
  input  logic [63:0]  word,
  input  logic [63:0]  target,
  output logic [255:0] digest,
  output logic         dig_full,
  output logic         hit
);

  localparam int CW = $clog2(DIG_WORDS);

  logic [CW-1:0] cnt;
  logic [63:0]   word_in;

`ifdef JH_SCHED_BYTESWAP_EN
  assign word_in = bswap64(word);
`else
  assign word_in = word;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      digest <= '0;
      cnt    <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift) begin
      digest <= {word_in, digest[255:64]};
      cnt    <= (cnt == CW'(DIG_WORDS-1)) ? '0 : cnt + 1'b1;
    end
  end

  // Fires on the cycle of the final write so the FSM lands in CHECK with a complete digest.
  assign dig_full = shift && !clr && (cnt == CW'(DIG_WORDS-1));
  assign hit      = (digest[255:192] <= target);

endmodule

// File: rtl/jh_nonce_scheduler.sv
// Drives one JH core through a nonce sweep over an 80-byte header, stopping on first digest <= target.
// Build option JH_SCHED_BYTESWAP_EN byte-reverses each digest word before collection.
module jh_nonce_scheduler
  import jh_sched_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  output logic         jh_rst,
  output logic         jh_src_ready_n,
  input  logic         jh_src_read,
  output logic [63:0]  jh_din,
  output logic         jh_dst_ready_n,
  input  logic         jh_dst_write,
  input  logic [63:0]  jh_dout,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] digest,
  output logic [31:0]  nonces_done
);

  state_t      state, state_n;
  logic [31:0] hdr [20];
  logic [63:0] target;
  logic [31:0] nonce_start, nonce_count, nonce, remaining;
  logic [3:0]  widx;
  logic        abort_q, ctrl_wr, abort, start_take, dig_shift, dig_full, hit;

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign jh_rst     = reset | abort_q;
  assign ctrl_wr    = cfg_we && (cfg_addr == ADDR_CTRL);
  assign abort      = ctrl_wr && cfg_wdata[1];
  assign start_take = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1] && !busy;
  assign dig_shift  = jh_dst_write && (state == WAIT_DIG) && !abort;

  jh_digest_collector u_collector (
    .clk      (clk),
    .reset    (reset),
    .clr      (abort | start_take),
    .shift    (dig_shift),
    .word     (jh_dout),
    .target   (target),
    .digest   (digest),
    .dig_full (dig_full),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    jh_src_ready_n = 1'b1;
    jh_dst_ready_n = 1'b1;
    jh_din         = '0;
    case (state)
      IDLE, DONE: if (start_take) state_n = (nonce_count == '0) ? DONE : SEND_HDR;
      SEND_HDR: begin
        jh_src_ready_n = 1'b0;
        jh_din         = 64'(MSG_LEN_BITS);
        if (jh_src_read) state_n = SEND_MSG;
      end
      SEND_MSG: begin
        jh_src_ready_n = 1'b0;
        // The nonce occupies the top half of the final message word.
        jh_din = {(widx == 4'(MSG_WORDS-1)) ? nonce : hdr[{widx, 1'b1}], hdr[{widx, 1'b0}]};
        if (jh_src_read && widx == 4'(MSG_WORDS-1)) state_n = WAIT_DIG;
      end
      WAIT_DIG: begin
        jh_dst_ready_n = 1'b0;
        if (dig_full) state_n = CHECK;
      end
      CHECK:   state_n = (hit || remaining == 32'd1) ? DONE : SEND_HDR;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 20; i++) hdr[i] <= '0;
      target      <= '0;
      nonce_start <= '0;
      nonce_count <= '0;
      nonce       <= '0;
      remaining   <= '0;
      widx        <= '0;
      abort_q     <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      nonces_done <= '0;
    end else begin
      abort_q <= abort;
      if (cfg_we && !busy) begin
        if (cfg_addr < ADDR_TGT_LO) hdr[cfg_addr] <= cfg_wdata;
        case (cfg_addr)
          ADDR_TGT_LO:      target[31:0]  <= cfg_wdata;
          ADDR_TGT_HI:      target[63:32] <= cfg_wdata;
          ADDR_NONCE_START: nonce_start   <= cfg_wdata;
          ADDR_NONCE_COUNT: nonce_count   <= cfg_wdata;
          default: ;
        endcase
      end
      if (abort) begin
        found <= 1'b0;
        widx  <= '0;
      end else if (start_take) begin
        nonce       <= nonce_start;
        remaining   <= nonce_count;
        nonces_done <= '0;
        found       <= 1'b0;
        found_nonce <= '0;
        widx        <= '0;
      end else begin
        case (state)
          SEND_MSG: if (jh_src_read) widx <= (widx == 4'(MSG_WORDS-1)) ? '0 : widx + 1'b1;
          CHECK: begin
            nonces_done <= nonces_done + 1'b1;
            if (hit) begin
              found       <= 1'b1;
              found_nonce <= nonce;
            end else if (remaining != 32'd1) begin
              nonce     <= nonce + 1'b1;
              remaining <= remaining - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jh_nonce_scheduler.sv
// Bench for jh_nonce_scheduler: behavioural JH core model plus a scoreboard of expected input words.
module tb_jh_nonce_scheduler;
  import jh_sched_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_we;
  logic [4:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic         jh_rst, jh_src_ready_n, jh_src_read, jh_dst_ready_n, jh_dst_write;
  logic [63:0]  jh_din, jh_dout;
  logic         busy, done, found;
  logic [31:0]  found_nonce, nonces_done;
  logic [255:0] digest;

  always #5 clk = ~clk;

  jh_nonce_scheduler dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .jh_rst(jh_rst), .jh_src_ready_n(jh_src_ready_n), .jh_src_read(jh_src_read), .jh_din(jh_din),
    .jh_dst_ready_n(jh_dst_ready_n), .jh_dst_write(jh_dst_write), .jh_dout(jh_dout),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce), .digest(digest),
    .nonces_done(nonces_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hdr [20];
  logic [63:0] exp_q [$];
  int          stall_word = -1, stall_len = 0, stall_left = 0;
  int          dig_limit = 4;
  bit          use_override = 1'b0;
  logic [63:0] override_word = 64'h0102030405060708;
  int          reads = 0, dig_sent = 0, src_low_cnt = 0;

  function automatic logic [63:0] dig_word(input logic [31:0] n, input int k);
    return {8'(k + 1), 24'h0, ~n};
  endfunction

  function automatic logic [63:0] sw(input logic [63:0] w);
`ifdef JH_SCHED_BYTESWAP_EN
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[(7-i)*8 +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  function automatic logic [255:0] exp_digest(input logic [31:0] n);
    logic [63:0] w3;
    w3 = use_override ? override_word : dig_word(n, 3);
    return {sw(w3), sw(dig_word(n, 2)), sw(dig_word(n, 1)), sw(dig_word(n, 0))};
  endfunction

  // Core model: consumes 11 words, then returns dig_limit digest words for the nonce it saw.
  initial begin : core_model
    int          rd_cnt;
    int          di;
    logic [31:0] cur_n;
    logic [63:0] held, e;
    rd_cnt = 0; di = -1; cur_n = '0; held = '0;
    jh_src_read = 1'b0; jh_dst_write = 1'b0; jh_dout = '0;
    forever begin
      @(negedge clk);
      jh_src_read  = 1'b0;
      jh_dst_write = 1'b0;
      if (jh_rst) begin
        rd_cnt = 0; di = -1;
        continue;
      end
      if (!jh_src_ready_n) src_low_cnt++;
      if (di >= 0) begin
        if (!jh_dst_ready_n) begin
          jh_dout      = (di == 3 && use_override) ? override_word : dig_word(cur_n, di);
          jh_dst_write = 1'b1;
          dig_sent++;
          di++;
          if (di == dig_limit || di == 4) di = -1;
        end
      end else if (!jh_src_ready_n) begin
        if (rd_cnt == stall_word && stall_left > 0) begin
          if (stall_left == stall_len) held = jh_din;
          else begin
            n_checks++;
            if (jh_din !== held) begin
              n_fail++;
              $display("FAIL stall_stable: jh_din=%h required %h", jh_din, held);
            end
          end
          stall_left--;
        end else begin
          e = '0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: jh_din=%h required no word", jh_din);
          end else begin
            e = exp_q.pop_front();
            if (jh_din !== e) begin
              n_fail++;
              $display("FAIL sb_word%0d: jh_din=%h required %h", rd_cnt, jh_din, e);
            end
          end
          if (rd_cnt == 10) cur_n = e[63:32];
          jh_src_read = 1'b1;
          reads++;
          rd_cnt++;
          if (rd_cnt == 11) begin
            rd_cnt = 0;
            di = 0;
          end
        end
      end
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg(input logic [63:0] tgt, input logic [31:0] ns, input logic [31:0] nc);
    for (int i = 0; i < 20; i++) cfg_write(5'(i), hdr[i]);
    cfg_write(ADDR_TGT_LO, tgt[31:0]);
    cfg_write(ADDR_TGT_HI, tgt[63:32]);
    cfg_write(ADDR_NONCE_START, ns);
    cfg_write(ADDR_NONCE_COUNT, nc);
  endtask

  task automatic push_nonces(input logic [31:0] ns, input int n);
    logic [31:0] nn;
    for (int i = 0; i < n; i++) begin
      nn = ns + 32'(i);
      exp_q.push_back(64'd640);
      for (int w = 0; w < 10; w++)
        exp_q.push_back({(w == 9) ? nn : hdr[2*w+1], hdr[2*w]});
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%b required 1", name, done);
    end
  endtask

  task automatic check_result(input string name, input logic f, input logic [31:0] fn,
                              input logic [31:0] nd, input logic [255:0] dg);
    n_checks++;
    if (found !== f) begin n_fail++; $display("FAIL %s_found: %b required %b", name, found, f); end
    if (f) begin
      n_checks++;
      if (found_nonce !== fn) begin n_fail++; $display("FAIL %s_found_nonce: %h required %h", name, found_nonce, fn); end
    end
    n_checks++;
    if (nonces_done !== nd) begin n_fail++; $display("FAIL %s_nonces_done: %0d required %0d", name, nonces_done, nd); end
    n_checks++;
    if (digest !== dg) begin n_fail++; $display("FAIL %s_digest: %h required %h", name, digest, dg); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_sb_left: %0d words required 0", name, exp_q.size()); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: %b required 0", name, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (jh_rst !== 1'b1) begin n_fail++; $display("FAIL reset_jh_rst: %b required 1", jh_rst); end
    n_checks++;
    if ({jh_src_ready_n, jh_dst_ready_n} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready_n: %b required 11", {jh_src_ready_n, jh_dst_ready_n});
    end
    n_checks++;
    if ({busy, done, found, found_nonce, nonces_done, digest, jh_din} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b done=%b found=%b fn=%h nd=%h dig=%h din=%h required all 0",
                         busy, done, found, found_nonce, nonces_done, digest, jh_din);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (jh_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release: jh_rst=%b required 0", jh_rst); end
  endtask

  task automatic test_single_hit();
    int r0;
    load_cfg(64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 32'd1);
    r0 = reads;
    push_nonces(32'd5, 1);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_done("single");
    check_result("single", 1'b1, 32'd5, 32'd1, exp_digest(32'd5));
    n_checks++;
    if (reads - r0 != 11) begin n_fail++; $display("FAIL single_reads: %0d required 11", reads - r0); end
  endtask

  task automatic test_wrap_miss();
    load_cfg(64'h0, 32'hFFFF_FFFE, 32'd3);
    push_nonces(32'hFFFF_FFFE, 3);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_done("wrap");
    check_result("wrap", 1'b0, 32'd0, 32'd3, exp_digest(32'h0));
  endtask

  task automatic test_mid_hit();
    load_cfg({8'h04, 24'h0, ~32'd12}, 32'd10, 32'd5);
    push_nonces(32'd10, 3);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_done("mid");
    check_result("mid", 1'b1, 32'd12, 32'd3, exp_digest(32'd12));
  endtask

  task automatic test_zero_count();
    int s0;
    cfg_write(ADDR_NONCE_COUNT, 32'd0);
    s0 = src_low_cnt;
    cfg_write(ADDR_CTRL, 32'h1);
    if (!done) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || found !== 1'b0 || nonces_done !== 32'd0) begin
      n_fail++; $display("FAIL zero_count: done=%b found=%b nd=%0d required 1 0 0", done, found, nonces_done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (src_low_cnt != s0) begin n_fail++; $display("FAIL zero_src: %0d low cycles required 0", src_low_cnt - s0); end
  endtask

  task automatic test_stall();
    load_cfg(64'hFFFF_FFFF_FFFF_FFFF, 32'd77, 32'd1);
    stall_word = 5; stall_len = 7; stall_left = 7;
    push_nonces(32'd77, 1);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_done("stall");
    check_result("stall", 1'b1, 32'd77, 32'd1, exp_digest(32'd77));
    n_checks++;
    if (stall_left != 0) begin n_fail++; $display("FAIL stall_taken: left=%0d required 0", stall_left); end
    stall_word = -1;
  endtask

  task automatic test_abort();
    int d0, t;
    load_cfg(64'hFFFF_FFFF_FFFF_FFFF, 32'd200, 32'd1);
    dig_limit = 2;
    push_nonces(32'd200, 1);
    d0 = dig_sent;
    cfg_write(ADDR_CTRL, 32'h1);
    t = 0;
    while (dig_sent - d0 < 2 && t < 500) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || jh_dst_ready_n !== 1'b0) begin
      n_fail++; $display("FAIL abort_pre: busy=%b dst_ready_n=%b required 1 0", busy, jh_dst_ready_n);
    end
    cfg_write(ADDR_CTRL, 32'h3);
    n_checks++;
    if (jh_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0) begin
      n_fail++; $display("FAIL abort_pulse: rst=%b busy=%b done=%b found=%b required 1 0 0 0", jh_rst, busy, done, found);
    end
    @(negedge clk);
    n_checks++;
    if (jh_rst !== 1'b0) begin n_fail++; $display("FAIL abort_width: jh_rst=%b required 0", jh_rst); end
    dig_limit = 4;
    push_nonces(32'd200, 1);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_done("restart");
    check_result("restart", 1'b1, 32'd200, 32'd1, exp_digest(32'd200));
  endtask

  task automatic test_byteswap();
    logic [63:0] want;
`ifdef JH_SCHED_BYTESWAP_EN
    want = 64'h0807060504030201;
`else
    want = 64'h0102030405060708;
`endif
    use_override = 1'b1;
    load_cfg(64'hFFFF_FFFF_FFFF_FFFF, 32'd300, 32'd1);
    push_nonces(32'd300, 1);
    cfg_write(ADDR_CTRL, 32'h1);
    wait_done("bswap");
    n_checks++;
    if (digest[255:192] !== want) begin n_fail++; $display("FAIL bswap_top: %h required %h", digest[255:192], want); end
    check_result("bswap", 1'b1, 32'd300, 32'd1, exp_digest(32'd300));
    use_override = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) hdr[i] = 32'hA500_0000 + 32'(i * 32'h0101_0037);
    test_reset();
    test_single_hit();
    test_wrap_miss();
    test_mid_hit();
    test_zero_count();
    test_stall();
    test_abort();
    test_byteswap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
